header_capture_unit: RTL

HEADER_CAPTURE_UNIT -- requirements
Module: header_capture_unit

---
 rtl/header_capture_unit_pkg.sv | 30 +++
 rtl/header_capture_unit_if.sv | 33 +++
 rtl/header_capture_unit_len_resolver.sv | 42 ++++
 rtl/header_capture_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/header_capture_unit_pkg.sv
// rtl/header_capture_unit_pkg.sv - shared constants, FSM state type and helpers for header capture
// Package hdr_capture_pkg: TPID values, header length constants, FSM states.
// Config macro: HDR_CAPTURE_QINQ_EN selects a 22-byte header slot (QinQ) instead of 18.
package hdr_capture_pkg;

  localparam logic [15:0] TPID_VLAN = 16'h8100;
  localparam logic [15:0] TPID_QINQ = 16'h88A8;

  localparam int ETH_BASE_HDR_BYTES = 14;
  localparam int VLAN_HDR_BYTES     = 18;
  localparam int QINQ_HDR_BYTES     = 22;

`ifdef HDR_CAPTURE_QINQ_EN
  localparam int MAX_HDR_BYTES = QINQ_HDR_BYTES;
`else
  localparam int MAX_HDR_BYTES = VLAN_HDR_BYTES;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2
  } hdr_state_e;

  // Network byte order: byte idx is the most significant half.
  function automatic logic [15:0] hdr_be16(input logic [MAX_HDR_BYTES*8-1:0] b, input int idx);
    return {b[8*idx +: 8], b[8*idx+8 +: 8]};
  endfunction

endpackage

// File: rtl/header_capture_unit_if.sv
// rtl/header_capture_unit_if.sv - stream input and header output bundle for header_capture_unit
// Signals: beat_accept/axis_tdata/axis_tkeep/axis_tlast (stream in),
//          hdr_bytes/hdr_len/hdr_vlan_tags/hdr_short/hdr_valid/hdr_ready (header out), drop_cnt.
// Modports: slave = capture unit view, master = source/sink view.
// Config macro: HDR_CAPTURE_QINQ_EN (via MAX_HDR_BYTES width of hdr_bytes).
interface header_capture_unit_if import hdr_capture_pkg::*; #(
  parameter int DATA_WIDTH = 64
) ();

  logic                         beat_accept;
  logic [DATA_WIDTH-1:0]        axis_tdata;
  logic [DATA_WIDTH/8-1:0]      axis_tkeep;
  logic                         axis_tlast;

  logic [MAX_HDR_BYTES*8-1:0]   hdr_bytes;
  logic [4:0]                   hdr_len;
  logic [1:0]                   hdr_vlan_tags;
  logic                         hdr_short;
  logic                         hdr_valid;
  logic                         hdr_ready;
  logic [15:0]                  drop_cnt;

  modport slave (
    input  beat_accept, axis_tdata, axis_tkeep, axis_tlast, hdr_ready,
    output hdr_bytes, hdr_len, hdr_vlan_tags, hdr_short, hdr_valid, drop_cnt
  );

  modport master (
    output beat_accept, axis_tdata, axis_tkeep, axis_tlast, hdr_ready,
    input  hdr_bytes, hdr_len, hdr_vlan_tags, hdr_short, hdr_valid, drop_cnt
  );

endinterface

// File: rtl/header_capture_unit_len_resolver.sv
// rtl/header_capture_unit_len_resolver.sv - combinational header target length and VLAN tag resolver
// Module hdr_len_resolver.
// Ports: buf_bytes (packed header bytes, byte 0 at [7:0]), byte_cnt (bytes held),
//        target_len (bytes the header needs), vlan_tags (tags detected so far).
// Config macro: HDR_CAPTURE_QINQ_EN adds 0x88A8 outer TPID and a second 0x8100 tag.
module hdr_len_resolver import hdr_capture_pkg::*; (
  input  logic [MAX_HDR_BYTES*8-1:0] buf_bytes,
  input  logic [4:0]                 byte_cnt,
  output logic [4:0]                 target_len,
  output logic [1:0]                 vlan_tags
);

  // Only bytes 12..17 influence the result; fold the rest so the full buffer is consumed.
  logic unused_buf;
  assign unused_buf = ^buf_bytes;

  always_comb begin
    target_len = 5'(ETH_BASE_HDR_BYTES);
    vlan_tags  = 2'd0;
    if (byte_cnt >= 5'(ETH_BASE_HDR_BYTES)) begin
      if (hdr_be16(buf_bytes, 12) == TPID_VLAN) begin
        target_len = 5'(VLAN_HDR_BYTES);
        vlan_tags  = 2'd1;
      end
`ifdef HDR_CAPTURE_QINQ_EN
      else if (hdr_be16(buf_bytes, 12) == TPID_QINQ) begin
        target_len = 5'(VLAN_HDR_BYTES);
        vlan_tags  = 2'd1;
      end
`endif
    end
`ifdef HDR_CAPTURE_QINQ_EN
    // Inner tag follows either outer TPID.
    if (target_len == 5'(VLAN_HDR_BYTES) && byte_cnt >= 5'(VLAN_HDR_BYTES) &&
        hdr_be16(buf_bytes, 16) == TPID_VLAN) begin
      target_len = 5'(QINQ_HDR_BYTES);
      vlan_tags  = 2'd2;
    end
`endif
  end

endmodule

// File: rtl/header_capture_unit.sv
// rtl/header_capture_unit.sv - captures the Ethernet/VLAN header from the start of each stream frame
// Ports: clk, rst_n (async active-low), bus (header_capture_unit_if.slave):
//   stream in  : beat_accept, axis_tdata, axis_tkeep, axis_tlast
//   header out : hdr_bytes, hdr_len, hdr_vlan_tags, hdr_short, hdr_valid/hdr_ready, drop_cnt
// Config macro: HDR_CAPTURE_QINQ_EN (QinQ recognition, 22-byte header slot).
module header_capture_unit import hdr_capture_pkg::*; #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  header_capture_unit_if.slave   bus
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int HB    = MAX_HDR_BYTES * 8;

  hdr_state_e      state;
  logic [HB-1:0]   wbuf;
  logic [4:0]      wcnt;

  logic [HB-1:0]   pack_buf;
  logic [4:0]      pack_cnt;
  logic [HB-1:0]   cap_buf;
  logic [4:0]      cap_cnt;
  logic [4:0]      target_len;
  logic [1:0]      vlan_tags;
  logic            reached;
  logic            hdr_done;

  logic [HB-1:0]   hdr_bytes_q;
  logic [4:0]      hdr_len_q;
  logic [1:0]      hdr_tags_q;
  logic            hdr_short_q;
  logic            hdr_valid_q;
  logic [15:0]     drop_cnt_q;

  // Pack kept lanes after the bytes already held; a new frame starts from an empty buffer.
  always_comb begin
    int idx;
    pack_buf = (state == CAPTURE) ? wbuf : '0;
    idx      = (state == CAPTURE) ? int'(wcnt) : 0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.axis_tkeep[i] && idx < MAX_HDR_BYTES) begin
        pack_buf[8*idx +: 8] = bus.axis_tdata[8*i +: 8];
        idx = idx + 1;
      end
    end
    pack_cnt = 5'(idx);
  end

  // Resolving on the whole packed beat lets one wide beat settle the final length.
  hdr_len_resolver u_resolver (
    .buf_bytes  (pack_buf),
    .byte_cnt   (pack_cnt),
    .target_len (target_len),
    .vlan_tags  (vlan_tags)
  );

  // Trim to the target so bytes past the header never reach the slot.
  always_comb begin
    reached = (pack_cnt >= target_len);
    cap_cnt = reached ? target_len : pack_cnt;
    cap_buf = pack_buf;
    for (int j = 0; j < MAX_HDR_BYTES; j++) begin
      if (5'(j) >= cap_cnt) cap_buf[8*j +: 8] = 8'h00;
    end
  end

  assign hdr_done = bus.beat_accept && (state != SKIP) && (reached || bus.axis_tlast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wbuf  <= '0;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE, CAPTURE: begin
          if (bus.beat_accept) begin
            wbuf <= cap_buf;
            wcnt <= cap_cnt;
            if (reached && !bus.axis_tlast) state <= SKIP;
            else if (bus.axis_tlast)        state <= IDLE;
            else                            state <= CAPTURE;
          end
        end
        SKIP: begin
          if (bus.beat_accept && bus.axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output slot: a completion is taken if the slot is empty or drained this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_bytes_q <= '0;
      hdr_len_q   <= '0;
      hdr_tags_q  <= '0;
      hdr_short_q <= 1'b0;
      hdr_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (hdr_valid_q && bus.hdr_ready) hdr_valid_q <= 1'b0;
      if (hdr_done) begin
        if (!hdr_valid_q || bus.hdr_ready) begin
          hdr_bytes_q <= cap_buf;
          hdr_len_q   <= cap_cnt;
          hdr_tags_q  <= vlan_tags;
          hdr_short_q <= !reached;
          hdr_valid_q <= 1'b1;
        end else if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end
    end
  end

  assign bus.hdr_bytes     = hdr_bytes_q;
  assign bus.hdr_len       = hdr_len_q;
  assign bus.hdr_vlan_tags = hdr_tags_q;
  assign bus.hdr_short     = hdr_short_q;
  assign bus.hdr_valid     = hdr_valid_q;
  assign bus.drop_cnt      = drop_cnt_q;

endmodule
